store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter SB_ENTRIES, default params_pkg::SB_ENTRIES (4), meaning buffer depth (power of two, >=2).
REQ-002 SHALL have parameter ADDR_WIDTH, default params_pkg::ADDR_WIDTH (32), meaning address width; DATA_WIDTH likewise (32), meaning store data width.
REQ-003 SHALL have a single clock and an asynchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  async reset, active high.
REQ-004 SHALL have ports: alloc_valid_i  in  1  store leaving MEM; alloc_addr_i  in  ADDR_WIDTH; alloc_data_i  in  DATA_WIDTH; alloc_byte_i  in  1  1=byte store, 0=word; alloc_rob_idx_i  in  ROB_IDX_WIDTH.
REQ-005 SHALL have ports: commit_valid_i  in  1  ROB retires a store; commit_rob_idx_i  in  ROB_IDX_WIDTH; flush_i  in  1  discard uncommitted stores.
REQ-006 SHALL have ports: dc_req_valid_o  out  1; dc_req_addr_o  out  ADDR_WIDTH; dc_req_data_o  out  DATA_WIDTH; dc_req_byte_o  out  1; dc_req_ready_i  in  1; dc_done_i  in  1  cache write complete.
REQ-007 SHALL have ports: ld_valid_i  in  1; ld_addr_i  in  ADDR_WIDTH; ld_byte_i  in  1; fwd_hit_o  out  1; fwd_data_o  out  DATA_WIDTH; fwd_stall_o  out  1.
REQ-008 SHALL have ports: sb_full_o  out  1  (to hazard unit); sb_empty_o  out  1; count_o  out  $clog2(SB_ENTRIES)+1.

Function
REQ-009 SHALL hold entries in a circular array with three pointers (head=oldest, cmt=first uncommitted, tail=next free), each with one extra wrap bit; invariant head<=cmt<=tail in age order.
REQ-010 SHALL compute count_o=tail-head; sb_full_o=(count==SB_ENTRIES); sb_empty_o=(count==0); all from registered state only.
REQ-011 SHALL write entry at tail and advance tail when alloc_valid_i && !sb_full_o && !flush_i; alloc while full is dropped and flagged by assertion.
REQ-012 SHALL, on commit_valid_i, mark the entry at cmt committed and advance cmt only if its rob_idx equals commit_rob_idx_i and cmt!=tail; mismatch is ignored and flagged by assertion.
REQ-013 SHALL, on flush_i, set tail to cmt (after applying same-cycle commit), dropping all uncommitted entries; committed entries and an in-progress drain are unaffected.
REQ-014 SHALL drain with FSM IDLE/REQ/WAIT: IDLE->REQ when head!=cmt; REQ drives dc_req_valid_o=1 with head entry fields, stable until dc_req_ready_i, then ->WAIT; WAIT->IDLE on dc_done_i, advancing head same cycle.
REQ-015 SHALL permit alloc, commit, flush and head advance in the same cycle; new count reflects all applied events.
REQ-016 SHALL forward combinationally when ld_valid_i: scan valid entries (head..tail-1) youngest first, comparing addr[ADDR_WIDTH-1:2].
REQ-017 SHALL, on youngest match: word store -> fwd_hit_o=1, fwd_data_o=data (word load) or selected byte lane zero-extended (byte load); byte store with byte load at identical address -> hit, byte zero-extended; byte store with word load or different byte lane under a younger-miss -> fwd_stall_o=1, fwd_hit_o=0.
REQ-018 SHALL drive fwd_hit_o=fwd_stall_o=0 and fwd_data_o=0 when no match or ld_valid_i=0.
REQ-019 SHALL keep the entry being drained (REQ/WAIT) searchable until head advances.

Reset
REQ-020 SHALL on rst_i asynchronously clear head/cmt/tail to 0, all valid/committed bits to 0, FSM to IDLE; outputs: sb_full_o=0, sb_empty_o=1, count_o=0, dc_req_valid_o=0, fwd_* =0.
REQ-021 SHALL abandon an in-flight drain on reset mid-operation; dc_done_i after reset is ignored (FSM in IDLE).

Structure
REQ-022 SHALL place SB_ENTRIES, ADDR_WIDTH, DATA_WIDTH, ROB_IDX_WIDTH, sb_entry_t (addr, data, is_byte, rob_idx, committed) and sb_state_t in params_pkg.
REQ-023 SHALL implement forwarding search as sub-module sb_fwd_lookup; pointer/FSM logic stays in store_buffer.

Verification
REQ-024 Fill: 4 allocs, no commit -> sb_full_o=1, count_o=4; 5th alloc dropped; dc_req_valid_o stays 0.
REQ-025 Commit+drain: alloc word 0x100=0xDEADBEEF rob 3, commit rob 3, ready=1, done 2 cycles later -> one request addr 0x100 data 0xDEADBEEF; sb_empty_o=1 after done.
REQ-026 Flush: 3 allocs, commit first only, flush -> count_o=1, only first drained.
REQ-027 Forward: word store 0x200=0x11223344 then byte load 0x201 -> fwd_hit_o=1, fwd_data_o=0x33; byte store 0x204 then word load 0x204 -> fwd_stall_o=1.
REQ-028 Reset mid-drain: assert rst_i in WAIT -> all outputs at reset values next edge; later dc_done_i causes no pointer change.

Source files
------------

// File: rtl/params_pkg.sv
// rtl/params_pkg.sv - shared store buffer parameters, entry layout, drain states and byte helpers
package params_pkg;

  localparam int SB_ENTRIES    = 4;
  localparam int ADDR_WIDTH    = 32;
  localparam int DATA_WIDTH    = 32;
  localparam int ROB_IDX_WIDTH = 5;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    addr;
    logic [DATA_WIDTH-1:0]    data;
    logic                     is_byte;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
    logic                     committed;
  } sb_entry_t;

  typedef logic [1:0] sb_state_t;
  localparam sb_state_t SB_IDLE = 2'd0;
  localparam sb_state_t SB_REQ  = 2'd1;
  localparam sb_state_t SB_WAIT = 2'd2;

  // Little-endian lane select within a 32-bit word.
  function automatic logic [7:0] byte_lane(input logic [DATA_WIDTH-1:0] word,
                                           input logic [1:0]            lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] byte_zext(input logic [7:0] b);
    return {{(DATA_WIDTH-8){1'b0}}, b};
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store buffer alloc, commit, dcache drain and load-forward signal bundle
interface store_buffer_if #(
  parameter int SB_ENTRIES    = params_pkg::SB_ENTRIES,
  parameter int ADDR_WIDTH    = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH    = params_pkg::DATA_WIDTH,
  parameter int ROB_IDX_WIDTH = params_pkg::ROB_IDX_WIDTH
);

  logic                     alloc_valid_i;
  logic [ADDR_WIDTH-1:0]    alloc_addr_i;
  logic [DATA_WIDTH-1:0]    alloc_data_i;
  logic                     alloc_byte_i;
  logic [ROB_IDX_WIDTH-1:0] alloc_rob_idx_i;

  logic                     commit_valid_i;
  logic [ROB_IDX_WIDTH-1:0] commit_rob_idx_i;
  logic                     flush_i;

  logic                     dc_req_valid_o;
  logic [ADDR_WIDTH-1:0]    dc_req_addr_o;
  logic [DATA_WIDTH-1:0]    dc_req_data_o;
  logic                     dc_req_byte_o;
  logic                     dc_req_ready_i;
  logic                     dc_done_i;

  logic                     ld_valid_i;
  logic [ADDR_WIDTH-1:0]    ld_addr_i;
  logic                     ld_byte_i;
  logic                     fwd_hit_o;
  logic [DATA_WIDTH-1:0]    fwd_data_o;
  logic                     fwd_stall_o;

  logic                     sb_full_o;
  logic                     sb_empty_o;
  logic [$clog2(SB_ENTRIES):0] count_o;

  modport master (
    output alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_byte_i, alloc_rob_idx_i,
    output commit_valid_i, commit_rob_idx_i, flush_i,
    input  dc_req_valid_o, dc_req_addr_o, dc_req_data_o, dc_req_byte_o,
    output dc_req_ready_i, dc_done_i,
    output ld_valid_i, ld_addr_i, ld_byte_i,
    input  fwd_hit_o, fwd_data_o, fwd_stall_o,
    input  sb_full_o, sb_empty_o, count_o
  );

  modport slave (
    input  alloc_valid_i, alloc_addr_i, alloc_data_i, alloc_byte_i, alloc_rob_idx_i,
    input  commit_valid_i, commit_rob_idx_i, flush_i,
    output dc_req_valid_o, dc_req_addr_o, dc_req_data_o, dc_req_byte_o,
    input  dc_req_ready_i, dc_done_i,
    input  ld_valid_i, ld_addr_i, ld_byte_i,
    output fwd_hit_o, fwd_data_o, fwd_stall_o,
    output sb_full_o, sb_empty_o, count_o
  );

endinterface

// File: rtl/sb_fwd_lookup.sv
// rtl/sb_fwd_lookup.sv - combinational store-to-load forwarding search over live buffer entries
module sb_fwd_lookup #(
  parameter int SB_ENTRIES = params_pkg::SB_ENTRIES,
  parameter int ADDR_WIDTH = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = params_pkg::DATA_WIDTH,
  localparam int IDX_W     = $clog2(SB_ENTRIES),
  localparam int PTR_W     = IDX_W + 1
) (
  input  logic [ADDR_WIDTH-1:0] ent_addr [SB_ENTRIES],
  input  logic [DATA_WIDTH-1:0] ent_data [SB_ENTRIES],
  input  logic                  ent_byte [SB_ENTRIES],
  input  logic [PTR_W-1:0]      head,
  input  logic [PTR_W-1:0]      tail,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic                  ld_byte,
  output logic                  fwd_hit,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic                  fwd_stall
);
  import params_pkg::*;

  logic [PTR_W-1:0]      count;
  logic [IDX_W-1:0]      slot [SB_ENTRIES];
  logic                  live [SB_ENTRIES];
  logic                  match;
  logic [DATA_WIDTH-1:0] hit_data;
  logic                  hit_byte;
  logic [1:0]            hit_lane;

  assign count = tail - head;

  // slot[k] is the k-th oldest entry; live when it lies in head..tail-1.
  for (genvar g = 0; g < SB_ENTRIES; g++) begin : g_slot
    assign slot[g] = head[IDX_W-1:0] + IDX_W'(g);
    assign live[g] = PTR_W'(g) < count;
  end

  // Walking oldest to youngest lets the youngest match overwrite older ones.
  always_comb begin
    match    = 1'b0;
    hit_data = '0;
    hit_byte = 1'b0;
    hit_lane = 2'b00;
    for (int i = 0; i < SB_ENTRIES; i++) begin
      if (live[i] && ent_addr[slot[i]][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2]) begin
        match    = 1'b1;
        hit_data = ent_data[slot[i]];
        hit_byte = ent_byte[slot[i]];
        hit_lane = ent_addr[slot[i]][1:0];
      end
    end
  end

  // A byte store carries its value in data[7:0]; it cannot supply other lanes or a full word.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    if (ld_valid && match) begin
      if (!hit_byte) begin
        fwd_hit  = 1'b1;
        fwd_data = ld_byte ? byte_zext(byte_lane(hit_data, ld_addr[1:0])) : hit_data;
      end else if (ld_byte && hit_lane == ld_addr[1:0]) begin
        fwd_hit  = 1'b1;
        fwd_data = byte_zext(hit_data[7:0]);
      end else begin
        fwd_stall = 1'b1;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - post-MEM store buffer: circular queue with commit/flush, dcache drain FSM
module store_buffer #(
  parameter int SB_ENTRIES    = params_pkg::SB_ENTRIES,
  parameter int ADDR_WIDTH    = params_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH    = params_pkg::DATA_WIDTH,
  parameter int ROB_IDX_WIDTH = params_pkg::ROB_IDX_WIDTH
) (
  input logic           clk_i,
  input logic           rst_i,
  store_buffer_if.slave bus
);
  import params_pkg::*;

  localparam int IDX_W = $clog2(SB_ENTRIES);
  localparam int PTR_W = IDX_W + 1;

  typedef logic [PTR_W-1:0]         ptr_t;
  typedef logic [ROB_IDX_WIDTH-1:0] rob_t;

  sb_entry_t entries [SB_ENTRIES];
  ptr_t      head, cmt, tail;
  ptr_t      head_next, cmt_next, tail_next, count;
  sb_state_t state, state_next;
  logic      full, empty, alloc_fire, commit_fire, head_adv;

  logic [IDX_W-1:0] head_idx, cmt_idx, tail_idx;

  logic [ADDR_WIDTH-1:0] ent_addr [SB_ENTRIES];
  logic [DATA_WIDTH-1:0] ent_data [SB_ENTRIES];
  logic                  ent_byte [SB_ENTRIES];

  assign head_idx = head[IDX_W-1:0];
  assign cmt_idx  = cmt[IDX_W-1:0];
  assign tail_idx = tail[IDX_W-1:0];

  assign count = tail - head;
  assign full  = (count == ptr_t'(SB_ENTRIES));
  assign empty = (count == '0);

  assign alloc_fire  = bus.alloc_valid_i && !full && !bus.flush_i;
  assign commit_fire = bus.commit_valid_i && (cmt != tail) &&
                       (rob_t'(entries[cmt_idx].rob_idx) == bus.commit_rob_idx_i);
  assign head_adv    = (state == SB_WAIT) && bus.dc_done_i;

  // Flush rewinds tail onto the post-commit cmt, so a same-cycle commit survives it.
  assign cmt_next  = cmt + ptr_t'(commit_fire);
  assign tail_next = bus.flush_i ? cmt_next : tail + ptr_t'(alloc_fire);
  assign head_next = head + ptr_t'(head_adv);

  always_comb begin
    state_next = state;
    case (state)
      SB_IDLE: if (head != cmt)        state_next = SB_REQ;
      SB_REQ:  if (bus.dc_req_ready_i) state_next = SB_WAIT;
      SB_WAIT: if (bus.dc_done_i)      state_next = SB_IDLE;
      default:                         state_next = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head  <= '0;
      cmt   <= '0;
      tail  <= '0;
      state <= SB_IDLE;
      for (int i = 0; i < SB_ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else begin
      head  <= head_next;
      cmt   <= cmt_next;
      tail  <= tail_next;
      state <= state_next;
      if (alloc_fire) begin
        entries[tail_idx] <= '{addr:      bus.alloc_addr_i,
                               data:      bus.alloc_data_i,
                               is_byte:   bus.alloc_byte_i,
                               rob_idx:   bus.alloc_rob_idx_i,
                               committed: 1'b0};
      end
      if (commit_fire) begin
        entries[cmt_idx].committed <= 1'b1;
      end
    end
  end

  // The head entry is only ever committed while draining, so its fields hold steady through REQ.
  assign bus.dc_req_valid_o = (state == SB_REQ);
  assign bus.dc_req_addr_o  = entries[head_idx].addr;
  assign bus.dc_req_data_o  = entries[head_idx].data;
  assign bus.dc_req_byte_o  = entries[head_idx].is_byte;

  assign bus.sb_full_o  = full;
  assign bus.sb_empty_o = empty;
  assign bus.count_o    = count;

  for (genvar g = 0; g < SB_ENTRIES; g++) begin : g_ent
    assign ent_addr[g] = entries[g].addr;
    assign ent_data[g] = entries[g].data;
    assign ent_byte[g] = entries[g].is_byte;
  end

  sb_fwd_lookup #(
    .SB_ENTRIES (SB_ENTRIES),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fwd (
    .ent_addr  (ent_addr),
    .ent_data  (ent_data),
    .ent_byte  (ent_byte),
    .head      (head),
    .tail      (tail),
    .ld_valid  (bus.ld_valid_i),
    .ld_addr   (bus.ld_addr_i),
    .ld_byte   (bus.ld_byte_i),
    .fwd_hit   (bus.fwd_hit_o),
    .fwd_data  (bus.fwd_data_o),
    .fwd_stall (bus.fwd_stall_o)
  );

  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(bus.alloc_valid_i && full && !bus.flush_i))
        else $warning("store_buffer: alloc dropped, buffer full");
      assert (!(bus.commit_valid_i && !commit_fire))
        else $warning("store_buffer: commit ignored, rob_idx mismatch or nothing pending");
      assert (state == SB_IDLE || entries[head_idx].committed)
        else $error("store_buffer: draining an uncommitted entry");
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer: fill, drain, flush, forwarding, reset
module tb_store_buffer;
  import params_pkg::*;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic                  is_byte;
  } dc_exp_t;

  typedef struct packed {
    logic                  hit;
    logic                  stall;
    logic [DATA_WIDTH-1:0] data;
  } fwd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic auto_en = 1'b1;
  logic auto_done = 1'b0;
  logic manual_done = 1'b0;

  dc_exp_t  dc_q [$];
  fwd_exp_t fwd_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_buffer_if #(
    .SB_ENTRIES    (SB_ENTRIES),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ROB_IDX_WIDTH (ROB_IDX_WIDTH)
  ) bus ();

  store_buffer #(
    .SB_ENTRIES    (SB_ENTRIES),
    .ADDR_WIDTH    (ADDR_WIDTH),
    .DATA_WIDTH    (DATA_WIDTH),
    .ROB_IDX_WIDTH (ROB_IDX_WIDTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  assign bus.dc_done_i = auto_done | manual_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_status(input string tag, input int cnt, input logic fl, input logic em);
    check({tag, "_count"}, 32'(bus.count_o), 32'(cnt));
    check({tag, "_full"}, 32'(bus.sb_full_o), 32'(fl));
    check({tag, "_empty"}, 32'(bus.sb_empty_o), 32'(em));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [31:0] a, input logic [31:0] d, input logic b,
                       input logic [ROB_IDX_WIDTH-1:0] r);
    bus.alloc_valid_i   = 1'b1;
    bus.alloc_addr_i    = a;
    bus.alloc_data_i    = d;
    bus.alloc_byte_i    = b;
    bus.alloc_rob_idx_i = r;
    tick();
    bus.alloc_valid_i = 1'b0;
  endtask

  task automatic commit(input logic [ROB_IDX_WIDTH-1:0] r, input logic fl);
    bus.commit_valid_i   = 1'b1;
    bus.commit_rob_idx_i = r;
    bus.flush_i          = fl;
    tick();
    bus.commit_valid_i = 1'b0;
    bus.flush_i        = 1'b0;
  endtask

  task automatic do_flush();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic b, input logic eh, input logic es,
                      input logic [31:0] ed);
    fwd_q.push_back('{hit: eh, stall: es, data: ed});
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i  = a;
    bus.ld_byte_i  = b;
    tick();
    bus.ld_valid_i = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!bus.sb_empty_o && n < 100) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(bus.sb_empty_o), 32'd1);
  endtask

  // Cache model: acknowledge a write two cycles after its request handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en && !rst && bus.dc_req_valid_o && bus.dc_req_ready_i) begin
        @(posedge clk);
        @(posedge clk);
        #1 auto_done = 1'b1;
        @(posedge clk);
        #1 auto_done = 1'b0;
      end
    end
  end

  initial begin
    dc_exp_t  de;
    fwd_exp_t fe;
    forever begin
      @(negedge clk);
      if (!rst && bus.dc_req_valid_o && bus.dc_req_ready_i) begin
        if (dc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL dc_unexpected: got request addr 0x%0h, expected none", bus.dc_req_addr_o);
        end else begin
          de = dc_q.pop_front();
          check("dc_addr", bus.dc_req_addr_o, de.addr);
          check("dc_data", bus.dc_req_data_o, de.data);
          check("dc_byte", 32'(bus.dc_req_byte_o), 32'(de.is_byte));
        end
      end
      if (bus.ld_valid_i) begin
        if (fwd_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fwd_unexpected: got load 0x%0h with no expectation queued", bus.ld_addr_i);
        end else begin
          fe = fwd_q.pop_front();
          check("fwd_hit", 32'(bus.fwd_hit_o), 32'(fe.hit));
          check("fwd_stall", 32'(bus.fwd_stall_o), 32'(fe.stall));
          check("fwd_data", bus.fwd_data_o, fe.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    bus.alloc_valid_i    = 1'b0;
    bus.alloc_addr_i     = '0;
    bus.alloc_data_i     = '0;
    bus.alloc_byte_i     = 1'b0;
    bus.alloc_rob_idx_i  = '0;
    bus.commit_valid_i   = 1'b0;
    bus.commit_rob_idx_i = '0;
    bus.flush_i          = 1'b0;
    bus.dc_req_ready_i   = 1'b1;
    bus.ld_valid_i       = 1'b0;
    bus.ld_addr_i        = '0;
    bus.ld_byte_i        = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_status("reset", 0, 1'b0, 1'b1);
    check("reset_dc_valid", 32'(bus.dc_req_valid_o), 32'd0);
    check("reset_fwd_hit", 32'(bus.fwd_hit_o), 32'd0);
    check("reset_fwd_stall", 32'(bus.fwd_stall_o), 32'd0);
    check("reset_fwd_data", bus.fwd_data_o, 32'd0);
    rst = 1'b0;
    tick();
    check_status("post_reset", 0, 1'b0, 1'b1);

    // Fill with uncommitted stores; the fifth is dropped.
    for (int i = 0; i < 4; i++) begin
      alloc(32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, ROB_IDX_WIDTH'(i));
      check("fill_count", 32'(bus.count_o), 32'(i + 1));
    end
    check_status("full", 4, 1'b1, 1'b0);
    alloc(32'h20, 32'hFF, 1'b0, ROB_IDX_WIDTH'(4));
    check_status("full_drop", 4, 1'b1, 1'b0);
    load(32'h10, 1'b0, 1'b1, 1'b0, 32'hA0);
    tick();
    check("full_no_drain", 32'(bus.dc_req_valid_o), 32'd0);
    do_flush();
    check_status("fill_flushed", 0, 1'b0, 1'b1);

    // Single committed word store drains to the cache.
    alloc(32'h100, 32'hDEADBEEF, 1'b0, ROB_IDX_WIDTH'(3));
    dc_q.push_back('{addr: 32'h100, data: 32'hDEADBEEF, is_byte: 1'b0});
    commit(ROB_IDX_WIDTH'(3), 1'b0);
    check("drain_not_empty", 32'(bus.sb_empty_o), 32'd0);
    wait_empty("drain");
    check_status("drain_done", 0, 1'b0, 1'b1);

    // Flush keeps only the committed oldest entry.
    alloc(32'h300, 32'h01010101, 1'b0, ROB_IDX_WIDTH'(5));
    alloc(32'h304, 32'h02020202, 1'b0, ROB_IDX_WIDTH'(6));
    alloc(32'h308, 32'h03030303, 1'b1, ROB_IDX_WIDTH'(7));
    dc_q.push_back('{addr: 32'h300, data: 32'h01010101, is_byte: 1'b0});
    commit(ROB_IDX_WIDTH'(5), 1'b0);
    do_flush();
    check("flush_count", 32'(bus.count_o), 32'd1);
    wait_empty("flush");
    repeat (5) tick();

    // Commit and flush in the same cycle: the committed store survives.
    alloc(32'h340, 32'h77, 1'b0, ROB_IDX_WIDTH'(8));
    alloc(32'h344, 32'h88, 1'b0, ROB_IDX_WIDTH'(9));
    dc_q.push_back('{addr: 32'h340, data: 32'h77, is_byte: 1'b0});
    commit(ROB_IDX_WIDTH'(8), 1'b1);
    check("cflush_count", 32'(bus.count_o), 32'd1);
    wait_empty("cflush");

    // Forwarding: lanes, byte stores, youngest-wins, misses.
    alloc(32'h200, 32'h11223344, 1'b0, ROB_IDX_WIDTH'(10));
    load(32'h201, 1'b1, 1'b1, 1'b0, 32'h33);
    load(32'h200, 1'b0, 1'b1, 1'b0, 32'h11223344);
    alloc(32'h204, 32'hAB, 1'b1, ROB_IDX_WIDTH'(11));
    load(32'h204, 1'b0, 1'b0, 1'b1, 32'h0);
    load(32'h204, 1'b1, 1'b1, 1'b0, 32'hAB);
    load(32'h205, 1'b1, 1'b0, 1'b1, 32'h0);
    load(32'h300, 1'b0, 1'b0, 1'b0, 32'h0);
    alloc(32'h200, 32'h55667788, 1'b0, ROB_IDX_WIDTH'(12));
    check("fwd_count", 32'(bus.count_o), 32'd3);
    load(32'h200, 1'b0, 1'b1, 1'b0, 32'h55667788);
    load(32'h203, 1'b1, 1'b1, 1'b0, 32'h55);
    bus.ld_addr_i = 32'h200;
    #1;
    check("ld_idle_hit", 32'(bus.fwd_hit_o), 32'd0);
    check("ld_idle_data", bus.fwd_data_o, 32'd0);
    do_flush();
    check_status("fwd_flushed", 0, 1'b0, 1'b1);

    // Reset in the middle of a drain, then a stray done.
    auto_en = 1'b0;
    alloc(32'h500, 32'h0BADF00D, 1'b0, ROB_IDX_WIDTH'(14));
    dc_q.push_back('{addr: 32'h500, data: 32'h0BADF00D, is_byte: 1'b0});
    commit(ROB_IDX_WIDTH'(14), 1'b0);
    n = 0;
    while (!bus.dc_req_valid_o && n < 20) begin
      tick();
      n++;
    end
    check("mid_req_seen", 32'(bus.dc_req_valid_o), 32'd1);
    tick();
    check("mid_wait_valid", 32'(bus.dc_req_valid_o), 32'd0);
    load(32'h500, 1'b0, 1'b1, 1'b0, 32'h0BADF00D);
    fwd_q.push_back('{hit: 1'b0, stall: 1'b0, data: 32'h0});
    bus.ld_valid_i = 1'b1;
    bus.ld_addr_i  = 32'h500;
    bus.ld_byte_i  = 1'b0;
    rst = 1'b1;
    #1;
    check_status("mid_reset", 0, 1'b0, 1'b1);
    check("mid_reset_dc_valid", 32'(bus.dc_req_valid_o), 32'd0);
    tick();
    bus.ld_valid_i = 1'b0;
    rst = 1'b0;
    manual_done = 1'b1;
    tick();
    manual_done = 1'b0;
    check_status("stray_done", 0, 1'b0, 1'b1);
    check("stray_dc_valid", 32'(bus.dc_req_valid_o), 32'd0);
    alloc(32'h600, 32'h66, 1'b0, ROB_IDX_WIDTH'(1));
    check_status("post_stray_alloc", 1, 1'b0, 1'b0);
    do_flush();
    repeat (3) tick();

    check("dc_queue_left", 32'(dc_q.size()), 32'd0);
    check("fwd_queue_left", 32'(fwd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
